// File: rtl/cbf_out_pkg.sv
// Shared types and constants for the filter result serializer.
package cbf_out_pkg;

  // Word width of the upstream hybrid fixed-point filter output.
  localparam int FILTER_OUT_WIDTH = 14;

  // The serializer word width follows the filter output width by default.
  localparam int DEFAULT_WIDTH = FILTER_OUT_WIDTH;

  // Serializer FSM states.
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } ser_state_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous result FIFO with wrap-around pointers and a registered head word.
module result_fifo #(
  parameter  int WIDTH = 14,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic             one_left;
  logic [AW-1:0]    rd_next_idx;

  // The extra pointer bit separates a full FIFO from an empty one.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level       = wr_ptr - rd_ptr;
  assign do_pop      = pop && !empty;
  assign do_push     = push && (!full || do_pop);
  assign one_left    = (level == (AW+1)'(1));
  assign rd_next_idx = rd_ptr[AW-1:0] + AW'(1);

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Read and write pointers advance on accepted pops and pushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Head register always holds the oldest word, bypassing the array when the FIFO is (nearly) empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (do_pop) begin
      if (one_left) rd_data <= wr_data;
      else          rd_data <= mem[rd_next_idx];
    end else if (do_push && empty) begin
      rd_data <= wr_data;
    end
  end

endmodule

// File: rtl/cbf_result_serializer.sv
// Buffers decimated filter results and streams them off-chip as framed MSB-first serial words.
module cbf_result_serializer
  import cbf_out_pkg::*;
#(
  parameter  int WIDTH      = DEFAULT_WIDTH,
  parameter  int FIFO_DEPTH = 8,
  parameter  int CLK_DIV    = 2,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_strobe,
  input  logic             in_valid,
  output logic             sclk,
  output logic             sdata,
  output logic             frame,
  output logic             overflow,
  output logic [LW-1:0]    fifo_level
);

  localparam int            DW       = $clog2(2 * CLK_DIV);
  localparam int            BW       = $clog2(WIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-2:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic [WIDTH-1:0] head_word;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_req;
  logic             pop_req;
  logic             div_wrap;
  logic             start_word;

  // The head word leaves the FIFO at the end of LOAD, so a strobe in that cycle still fits.
  assign push_req   = in_strobe && in_valid;
  assign pop_req    = (state == LOAD);
  assign div_wrap   = (div_cnt == DIV_LAST);
  assign start_word = !fifo_empty && ((state == IDLE) || ((state == GAP) && div_wrap));

  result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_req),
    .pop     (pop_req),
    .wr_data (in_data),
    .rd_data (head_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Serializer FSM; the sdata flop acts as the shift register MSB and all line outputs are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      frame   <= 1'b0;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
    end else if (start_word) begin
      state   <= LOAD;
      shreg   <= head_word[WIDTH-2:0];
      bit_cnt <= BIT_LAST;
      div_cnt <= '0;
      frame   <= 1'b1;
      sclk    <= 1'b0;
      sdata   <= head_word[WIDTH-1];
    end else begin
      case (state)
        IDLE: state <= IDLE;
        LOAD: begin
          state   <= SHIFT;
          div_cnt <= '0;
        end
        SHIFT: begin
          if (div_wrap) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            if (bit_cnt == '0) begin
              state <= GAP;
              frame <= 1'b0;
              sdata <= 1'b0;
            end else begin
              sdata   <= shreg[WIDTH-2];
              shreg   <= {shreg[WIDTH-3:0], 1'b0};
              bit_cnt <= bit_cnt - BW'(1);
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
            sclk    <= ((div_cnt + DW'(1)) >= DIV_HALF);
          end
        end
        GAP: begin
          if (div_wrap) begin
            div_cnt <= '0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky flag for a sample dropped because the FIFO was full and nothing left it that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow <= 1'b0;
    else if (push_req && fifo_full && !pop_req) overflow <= 1'b1;
  end

endmodule

// File: doc/cbf_result_serializer.md
# cbf_result_serializer

Output stage placed directly downstream of the hybrid fixed-point filter top. It accepts the filter's 14-bit offset-binary result words at the decimated rate and buffers them in a small FIFO. It then streams each word off-chip as a framed, MSB-first serial word on a divided bit clock. The block runs entirely on the fast modulator clock and flags any sample lost to FIFO overflow.

## Interface
Parameters:
- WIDTH, 14, result word width; equals the filter output width.
- FIFO_DEPTH, 8, FIFO entries; power of two, at least 2.
- CLK_DIV, 2, clk cycles per sclk half-period; at least 1.

Ports:
- clk  input  1  modulator clock; the only clock in the block.
- rst  input  1  reset; asynchronous, active-low.
- in_data  input  WIDTH  filter result word; stable whenever in_strobe is high.
- in_strobe  input  1  one-clk pulse per decimated output sample, synchronous to clk.
- in_valid  input  1  filter valid flag; samples are ignored while it is low.
- sclk  output  1  serial bit clock; receiver samples sdata on its rising edge.
- sdata  output  1  serial data, MSB first.
- frame  output  1  high while a word is on the line.
- overflow  output  1  sticky; set when a sample is dropped.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Write rule: the FIFO pushes in_data on a clk edge where in_strobe and in_valid are both high and the FIFO is not full.
- Full handling: a push attempt while full drops the sample, leaves the FIFO unchanged and sets overflow. A pop in the same cycle frees an entry, so that push is accepted and overflow is not set.
- overflow is cleared only by rst.
- FSM states: IDLE, LOAD, SHIFT, GAP.
  - IDLE: if fifo_level > 0, go to LOAD on the next edge.
  - LOAD (1 cycle): pop the head word into the shift register. Set bit counter to WIDTH-1 and div counter to 0. Go to SHIFT.
  - SHIFT: the div counter counts 0 to 2*CLK_DIV-1. On wrap, if the bit counter is 0, go to GAP; otherwise shift left by one and decrement the bit counter.
  - GAP: frame, sclk and sdata are low for 2*CLK_DIV cycles, then go to IDLE.
- Outputs are decoded from registered state only, so they are glitch-free:
  - frame = 1 in LOAD and SHIFT.
  - sclk = 1 in SHIFT when div ≥ CLK_DIV; otherwise 0.
  - sdata = shift-register MSB in LOAD and SHIFT; 0 otherwise.
- sdata changes only while sclk is low, so it is stable for CLK_DIV cycles before each rising sclk edge.
- Words are sent unchanged; no sign conversion (the filter already emits offset binary).
- Reset mid-word: the FSM returns to IDLE and the FIFO empties. The frame aborts in the same cycle with no partial trailing bits.

## Timing
- Reset values: sclk=0, sdata=0, frame=0, overflow=0, fifo_level=0, state=IDLE.
- Pipeline: strobe at edge n → fifo_level=1 after edge n → LOAD after edge n+1, so frame rises one cycle later.
- Frame length: 1 + WIDTH*2*CLK_DIV cycles. Word period: frame length + 2*CLK_DIV cycles. Defaults give 57 + 4 = 61 clk.
- Sustained throughput requires word period ≤ decimation ratio × clk period. Otherwise the FIFO fills and overflow sets. Integrators choose CLK_DIV accordingly.
- fifo_level updates on the edge after a push or pop. A simultaneous push and pop leaves it unchanged.
- Bit k (MSB = k=0) rising sclk edge occurs at LOAD start + 1 + k*2*CLK_DIV + CLK_DIV cycles.

## Structure
- Package cbf_out_pkg holds:
  - the FSM state enum typedef (IDLE, LOAD, SHIFT, GAP);
  - default WIDTH, tied to the filter's output width constant.
- Sub-module result_fifo: synchronous FIFO with the same clk/rst, push/pop/full/empty/level outputs and registered read data. It uses wrap-around pointers with one extra bit for full/empty distinction.
- The top of this block contains only the FSM, shift register, counters and overflow flag.

## Test plan
- Reset: assert rst low mid-stream → all outputs 0 immediately (asynchronous); after release, first strobe produces a frame beginning 2 cycles later.
- Single word: in_data=14'h2A5C with strobe and valid, CLK_DIV=2 → frame high 57 cycles; 14 sclk rising edges sample 10101001011100; then frame, sclk and sdata are low for 4 cycles.
- Valid gating: strobes while in_valid=0 → fifo_level stays 0, no frame, overflow stays 0.
- Overflow: 9 strobes back-to-back with FIFO_DEPTH=8 and the serializer busy → 9th dropped, overflow=1 and sticky; 8 words emitted in order.
- Full with simultaneous pop: FIFO full, strobe in the LOAD cycle → push accepted, fifo_level stays 8, overflow stays 0.
- Sustained stream: strobe every 72 clk for 100 words with random data → received words equal the sent words and overflow=0 throughout.
